// File: rtl/add_row_sched.sv
// add_row_sched
//
// Sequencing controller for the residual Add stage. A single LANES-wide
// element-wise adder is time-multiplexed across every beat of a tensor pair.
// Both operand buffers are read in lock-step. The lane-wise sums are queued
// in a 2-entry output FIFO and handed downstream under valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin one operation (sampled only while idle)
//   busy       high while an operation is in progress
//   done       one-cycle pulse once the final sum beat has been accepted
//   rd_en      read request to both operand buffers
//   rd_addr    operand beat address, row-major
//   rd_data_a  operand A beat, valid the cycle after rd_en
//   rd_data_b  operand B beat, valid the cycle after rd_en
//   wr_valid   sum beat available at the FIFO head
//   wr_ready   downstream accepts the head beat
//   wr_addr    address of the head sum beat
//   wr_data    head sum beat, lane i at bits [(i+1)*WIDTH-1 : i*WIDTH]

module add_row_sched #(
    parameter  int ROW_NUM   = 128,
    parameter  int DIMENTION = 768,
    parameter  int LANES     = 64,
    parameter  int WIDTH     = 8,
    localparam int BEATS     = ROW_NUM * DIMENTION / LANES,
    localparam int AW        = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [AW-1:0]          rd_addr,
    input  logic [LANES*WIDTH-1:0] rd_data_a,
    input  logic [LANES*WIDTH-1:0] rd_data_b,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [AW-1:0]          wr_addr,
    output logic [LANES*WIDTH-1:0] wr_data
);

    localparam int DW = LANES * WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [AW-1:0]    addr_cnt;
    logic             inflight;
    logic [AW-1:0]    inflight_addr;

    logic [AW+DW-1:0] fifo_mem [2];
    logic             fifo_head;
    logic             fifo_tail;
    logic [1:0]       fifo_count;

    logic [DW-1:0]    sum;
    logic             pop;
    logic             push;
    logic [2:0]       occupancy;
    logic             slot_free;

    assign rd_addr  = addr_cnt;
    assign busy     = (state != IDLE);
    assign wr_valid = (fifo_count != 2'd0);
    assign wr_addr  = fifo_mem[fifo_head][AW+DW-1:DW];
    assign wr_data  = fifo_mem[fifo_head][DW-1:0];

    assign pop  = wr_valid & wr_ready;
    assign push = inflight;

    // Slots that will be taken once everything already requested lands.
    // A new read is allowed only if one slot is still free after that, so
    // the returning beat always finds room in the FIFO.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign slot_free = (occupancy < 3'd2);

    // Lane-wise wrapping add; WIDTH-bit truncation gives two's complement wrap.
    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum[i*WIDTH +: WIDTH] = rd_data_a[i*WIDTH +: WIDTH] + rd_data_b[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RUN leaves as soon as the last address has been requested; DRAIN
    // waits for both the read pipe and the FIFO to empty before finishing.
    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                rd_en = slot_free;
                if (slot_free && (addr_cnt == LAST_ADDR)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && !inflight) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The address restarts from zero on every accepted start and parks on
    // the last beat rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            addr_cnt <= '0;
        end else if (rd_en && (addr_cnt != LAST_ADDR)) begin
            addr_cnt <= addr_cnt + 1'b1;
        end
    end

    // Remember which address the returning operand data belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                inflight_addr <= addr_cnt;
            end
        end
    end

    // Two-entry output FIFO; the sum is pushed unconditionally the cycle
    // its operands return, which the issue rule keeps from overflowing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_head   <= 1'b0;
            fifo_tail   <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[fifo_tail] <= {inflight_addr, sum};
                fifo_tail           <= ~fifo_tail;
            end
            if (pop) begin
                fifo_head <= ~fifo_head;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_add_row_sched.sv
// tb_add_row_sched
//
// Directed bench for add_row_sched at its default geometry (1536 beats of
// 64 x 8-bit lanes). Operand buffers are modelled as synchronous memories
// whose contents are a function of address and a pattern mode. A negedge
// monitor tallies reads, handshakes and timing per operation, and the
// results are compared against hand-derived values at the end of each run.

module tb_add_row_sched;

    localparam int LANES = 64;
    localparam int WIDTH = 8;
    localparam int BEATS = 1536;
    localparam int AW    = 11;
    localparam int DW    = LANES * WIDTH;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int mode  = 0;
    bit mon_on = 1'b0;

    int rd_count, rd_errs, exp_rd, first_rd;
    int wv_count, first_wv, last_wv;
    int hs_count, beat_errs, exp_wr, stall_errs;
    int done_count, done_cycle, busy_count, busy_last;
    int occ, max_occ, occ_errs;
    bit infl;
    bit held_valid;
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_data;

    add_row_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand patterns: mode 0 all 127 + 1, mode 2 alternating wrap cases,
    // mode 1 address/lane dependent pseudo-random bytes.
    function automatic logic [7:0] byte_a(input int addr, input int lane, input int md);
        if (md == 0) return 8'd127;
        if (md == 2) return (lane % 2 == 0) ? 8'd127 : 8'h80;
        return 8'(addr * 37 + lane * 11 + 5);
    endfunction

    function automatic logic [7:0] byte_b(input int addr, input int lane, input int md);
        if (md == 0) return 8'd1;
        if (md == 2) return (lane % 2 == 0) ? 8'd1 : 8'hFF;
        return 8'(addr * 91 + lane * 53 + 200);
    endfunction

    function automatic logic [DW-1:0] beat_a(input int addr, input int md);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = byte_a(addr, i, md);
        return r;
    endfunction

    function automatic logic [DW-1:0] beat_b(input int addr, input int md);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = byte_b(addr, i, md);
        return r;
    endfunction

    // Expected sums: hand values for the wrap patterns (127+1 = -128,
    // -128 + -1 = 127), signed integer add truncated for the random pattern.
    function automatic logic [DW-1:0] exp_sum(input int addr, input int md);
        logic [DW-1:0] r;
        int s;
        for (int i = 0; i < LANES; i++) begin
            if (md == 0) begin
                r[i*WIDTH +: WIDTH] = 8'h80;
            end else if (md == 2) begin
                r[i*WIDTH +: WIDTH] = (i % 2 == 0) ? 8'h80 : 8'h7F;
            end else begin
                s = int'($signed(byte_a(addr, i, md))) + int'($signed(byte_b(addr, i, md)));
                r[i*WIDTH +: WIDTH] = s[7:0];
            end
        end
        return r;
    endfunction

    // Synchronous operand buffers: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= beat_a(int'(rd_addr), mode);
            rd_data_b <= beat_b(int'(rd_addr), mode);
        end
    end

    // Per-cycle monitor, sampled mid-cycle on the falling edge. occ is the
    // bench's own count of beats that should be sitting in the output FIFO.
    always @(negedge clk) begin
        if (mon_on) begin
            if (wr_valid !== (occ != 0)) occ_errs++;
            if (rd_en) begin
                if (rd_count == 0) first_rd = cyc - t0;
                if (int'(rd_addr) != exp_rd) rd_errs++;
                exp_rd++;
                rd_count++;
            end
            if (held_valid && !wr_valid) stall_errs++;
            if (wr_valid) begin
                if (wv_count == 0) first_wv = cyc - t0;
                last_wv = cyc - t0;
                wv_count++;
                if (held_valid && (wr_addr !== held_addr || wr_data !== held_data)) stall_errs++;
                if (wr_ready) begin
                    if (int'(wr_addr) != exp_wr || wr_data !== exp_sum(exp_wr, mode)) beat_errs++;
                    exp_wr++;
                    hs_count++;
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held_addr  = wr_addr;
                    held_data  = wr_data;
                end
            end else begin
                held_valid = 1'b0;
            end
            if (done) begin
                done_count++;
                done_cycle = cyc - t0;
            end
            if (busy) begin
                busy_count++;
                busy_last = cyc - t0;
            end
            occ = occ + int'(infl) - int'(wr_valid && wr_ready);
            if (occ > max_occ) max_occ = occ;
            infl = rd_en;
        end
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".busy"}, DW'(busy), DW'(0));
        checkOutput({tag, ".done"}, DW'(done), DW'(0));
        checkOutput({tag, ".rd_en"}, DW'(rd_en), DW'(0));
        checkOutput({tag, ".wr_valid"}, DW'(wr_valid), DW'(0));
        checkOutput({tag, ".rd_addr"}, DW'(rd_addr), DW'(0));
        checkOutput({tag, ".wr_addr"}, DW'(wr_addr), DW'(0));
        checkOutput({tag, ".wr_data"}, wr_data, DW'(0));
    endtask

    // One operation starting in relative cycle 0. rdy_mode: 0 always ready,
    // 1 ready at ~30% duty, 2 ready dropped over cycles 1537..1600.
    // extra adds start pulses at 10, 500 and 1539; rst_at >= 0 aborts the
    // run with a 2-cycle reset at that cycle. exp_done > 0 pins the done cycle.
    task automatic applyStimulus(input string name, input int md, input int rdy_mode,
                                 input bit extra, input int rst_at, input int exp_done);
        int rel;
        @(posedge clk);
        #1;
        mode = md;
        t0 = cyc;
        rd_count = 0; rd_errs = 0; exp_rd = 0; first_rd = -1;
        wv_count = 0; first_wv = -1; last_wv = -1;
        hs_count = 0; beat_errs = 0; exp_wr = 0; stall_errs = 0;
        done_count = 0; done_cycle = -1; busy_count = 0; busy_last = -1;
        occ = 0; max_occ = 0; occ_errs = 0; infl = 1'b0; held_valid = 1'b0;
        mon_on = 1'b1;
        start = 1'b1;
        wr_ready = 1'b1;
        $display("[TB] run %s", name);
        for (int n = 0; n < 8000; n++) begin
            @(posedge clk);
            #1;
            rel = cyc - t0;
            start = extra && (rel == 10 || rel == 500 || rel == 1539);
            case (rdy_mode)
                1:       wr_ready = ($urandom_range(0, 9) < 3);
                2:       wr_ready = !(rel >= 1537 && rel <= 1600);
                default: wr_ready = 1'b1;
            endcase
            if (rst_at >= 0) begin
                if (rel == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    checkIdleOutputs({name, ".in_rst0"});
                end else if (rel == rst_at + 1) begin
                    #1;
                    checkIdleOutputs({name, ".in_rst1"});
                end else if (rel == rst_at + 2) begin
                    rst_n = 1'b1;
                end else if (rel == rst_at + 3) begin
                    checkOutput({name, ".post_valid"}, DW'(wr_valid), DW'(0));
                    checkOutput({name, ".post_busy"}, DW'(busy), DW'(0));
                end else if (rel >= rst_at + 4) begin
                    break;
                end
            end
            if (done_count > 0 && rel >= done_cycle + 20) break;
        end
        mon_on = 1'b0;
        start = 1'b0;
        wr_ready = 1'b1;
        if (rst_at < 0) begin
            checkOutput({name, ".first_rd"}, DW'(first_rd), DW'(1));
            checkOutput({name, ".rd_count"}, DW'(rd_count), DW'(BEATS));
            checkOutput({name, ".rd_errs"}, DW'(rd_errs), DW'(0));
            checkOutput({name, ".first_wv"}, DW'(first_wv), DW'(3));
            checkOutput({name, ".handshakes"}, DW'(hs_count), DW'(BEATS));
            checkOutput({name, ".beat_errs"}, DW'(beat_errs), DW'(0));
            checkOutput({name, ".stall_errs"}, DW'(stall_errs), DW'(0));
            checkOutput({name, ".occ_errs"}, DW'(occ_errs), DW'(0));
            checkOutput({name, ".occ_le2"}, DW'(max_occ <= 2), DW'(1));
            checkOutput({name, ".done_count"}, DW'(done_count), DW'(1));
            checkOutput({name, ".busy_count"}, DW'(busy_count), DW'(done_cycle));
            checkOutput({name, ".busy_last"}, DW'(busy_last), DW'(done_cycle));
            if (exp_done > 0) begin
                checkOutput({name, ".done_cycle"}, DW'(done_cycle), DW'(exp_done));
            end
            if (rdy_mode == 0) begin
                checkOutput({name, ".last_wv"}, DW'(last_wv), DW'(1538));
                checkOutput({name, ".wv_count"}, DW'(wv_count), DW'(BEATS));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        wr_ready = 1'b1;
        rd_data_a = '0;
        rd_data_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        applyStimulus("wrap", 0, 0, 1'b1, -1, 1539);
        applyStimulus("alt", 2, 0, 1'b0, -1, 1539);
        applyStimulus("rand", 1, 0, 1'b0, -1, 1539);
        applyStimulus("bp", 1, 1, 1'b0, -1, 0);
        applyStimulus("rst", 1, 0, 1'b0, 700, 0);
        applyStimulus("after", 1, 0, 1'b0, -1, 1539);
        applyStimulus("tail", 1, 2, 1'b0, -1, 1603);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_row_sched.md
# add_row_sched

Sequencing controller for the residual Add stage. It time-multiplexes one LANES-wide element-wise adder across all ROW_NUM × DIMENTION elements of a tensor pair. It streams both operands beat by beat from two operand buffers and writes the sums to a result buffer under valid/ready backpressure. It sits between the operand SRAMs and the downstream LayerNorm input buffer, replacing a fully parallel adder array where area is constrained.

## Interface
- ROW_NUM, 128, token rows per tensor
- DIMENTION, 768, elements per row
- LANES, 64, elements added per beat; DIMENTION must be a multiple of LANES
- WIDTH, 8, signed element width of addends and sum
- BEATS (derived), ROW_NUM*DIMENTION/LANES = 1536, beats per operation
- AW (derived), $clog2(BEATS) = 11, beat address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin one operation; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final sum beat is accepted
- rd_en  out  1  read request to both operand buffers
- rd_addr  out  AW  beat address, row-major (row*DIMENTION/LANES + chunk)
- rd_data_a  in  LANES*WIDTH  operand A beat, valid the cycle after rd_en
- rd_data_b  in  LANES*WIDTH  operand B beat, valid the cycle after rd_en
- wr_valid  out  1  sum beat available
- wr_ready  in  1  downstream accepts the beat when high with wr_valid
- wr_addr  out  AW  address of the sum beat (equals its operand rd_addr)
- wr_data  out  LANES*WIDTH  sum beat, lane i at bits [(i+1)*WIDTH-1 : i*WIDTH]

## Operation
- FSM states:
  - IDLE to RUN on start.
  - RUN to DRAIN after rd_en has issued with rd_addr = BEATS-1.
  - DRAIN to IDLE once the read pipe and the output buffer are both empty after the final handshake; done pulses in that transition cycle.
- start while busy is ignored; no queuing.
- Arithmetic:
  - Per lane, sum = a + b in two's complement, truncated to WIDTH bits (wrap, no saturation).
  - Example: 127 + 1 = -128; -128 + -1 = 127.
- Output buffer is a 2-entry FIFO holding {addr, sum}.
- Sums are computed combinationally from rd_data_a/rd_data_b and pushed the cycle data returns; the push is unconditional.
- Read issue rule: in a cycle, rd_en may be high only when (fifo_count + inflight − pop) < 2.
  - inflight = rd_en of the previous cycle.
  - pop = wr_valid & wr_ready.
  - This guarantees the FIFO never overflows.
- rd_addr increments by 1 per issued read, 0 to BEATS-1, and never wraps within an operation.
- wr_valid = FIFO not empty. wr_data and wr_addr are the FIFO head and stay stable while wr_valid is high and wr_ready is low.
- Reset (rst_n low, at any time including mid-operation):
  - Immediately: state IDLE, busy=0, done=0, rd_en=0, wr_valid=0, rd_addr=0, wr_addr=0, wr_data=0.
  - FIFO and inflight are cleared and partial results are discarded.
  - The next start begins again from beat 0.

## Timing
- start high in cycle 0 with wr_ready held high: rd_en high in cycles 1..1536 with rd_addr 0..1535.
- Sum for a read issued in cycle k: wr_valid in cycle k+2. Throughput is 1 beat/cycle.
- With the same start and wr_ready high: wr_valid high in cycles 3..1538, done high in cycle 1539, busy high in cycles 1..1539.
- wr_ready low: at most one further read issues, then rd_en stays low until a pop frees a slot; no beat is lost or duplicated.
- Back-to-back operations: start may be asserted in the done cycle's following cycle (IDLE); a start in the done cycle itself is ignored.

## Test plan
- Directed wrap: A lanes all 127, B lanes all 1 at every address -> every wr_data lane = 0x80, 1536 beats, wr_addr 0..1535 in order, done in cycle 1539.
- Random full run with wr_ready=1: A/B random -> each beat equals the lane-wise truncated sum from the reference model; no gaps in wr_valid between cycles 3 and 1538.
- Backpressure: wr_ready random at 30% duty -> FIFO count never exceeds 2, wr_data/wr_addr stable while stalled, exactly 1536 unique handshakes, one done pulse.
- start pulses at cycles 10, 500 and 1539 after an initial start at cycle 0 -> only one operation runs; 1536 beats, a single done.
- rst_n low at cycle 700 for 2 cycles, then start -> all outputs 0 during reset; the new run restarts at rd_addr 0 and no stale beat appears.
- Stall at the last beat: wr_ready low from cycle 1537 to 1600 -> state holds in DRAIN, busy=1, done pulses the cycle after the last accepted beat.
